// File: rtl/echo_pkg.sv
// Shared definitions for the multi-channel echo: default sizes, a constant
// clog2 helper and the channel-index type for the default build.
package echo_pkg;

  localparam int ECHO_DEF_WIDTH = 32;
  localparam int ECHO_DEF_DEPTH = 4;
  localparam int ECHO_DEF_NCH   = 2;

  // Ceiling log2 usable in parameter expressions; bounded loop keeps it synthesizable.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Channel index width: at least one bit, even for a single channel.
  function automatic int chan_w(input int nch);
    return (clog2(nch) < 1) ? 1 : clog2(nch);
  endfunction

  localparam int ECHO_DEF_CHW = chan_w(ECHO_DEF_NCH);

  typedef logic [ECHO_DEF_CHW-1:0] chan_idx_t;

endpackage

// File: rtl/echo_multi_if.sv
// Handshake bundle between the request portal, the echo core and the
// indication portal. The host side is the master, the echo core the slave.
interface echo_multi_if
  import echo_pkg::*;
#(
  parameter int NCH   = ECHO_DEF_NCH,
  parameter int WIDTH = ECHO_DEF_WIDTH
) ();

  localparam int CHW = chan_w(NCH);

  logic [NCH-1:0]       say__ENA;
  logic [NCH*WIDTH-1:0] say_v;
  logic [NCH-1:0]       say__RDY;
  logic                 respond_rule__ENA;
  logic                 respond_rule__RDY;
  logic                 ind_heard__ENA;
  logic [WIDTH-1:0]     ind_heard_v;
  logic [CHW-1:0]       ind_heard_ch;
  logic                 ind_heard__RDY;

  modport master (
    output say__ENA, say_v, respond_rule__ENA, ind_heard__RDY,
    input  say__RDY, respond_rule__RDY, ind_heard__ENA, ind_heard_v, ind_heard_ch
  );

  modport slave (
    input  say__ENA, say_v, respond_rule__ENA, ind_heard__RDY,
    output say__RDY, respond_rule__RDY, ind_heard__ENA, ind_heard_v, ind_heard_ch
  );

endinterface

// File: rtl/echo_fifo.sv
// Per-channel circular buffer. Enqueue is refused while full and dequeue
// while empty, so a full buffer never passes a word through in one cycle.
module echo_fifo
  import echo_pkg::*;
#(
  parameter int WIDTH = ECHO_DEF_WIDTH,
  parameter int DEPTH = ECHO_DEF_DEPTH
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_enq,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_deq,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_enq;
  logic             w_do_deq;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_head   = r_mem[r_rd_ptr];
  assign w_do_enq = i_enq & ~o_full;
  assign w_do_deq = i_deq & ~o_empty;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_enq) - (AW+1)'(w_do_deq);
    end
  end

  // Storage write.
  // NOTE: the data array is deliberately not reset; empty/full come from the count, so stale words are never observed.
  always_ff @(posedge CLK) begin
    if (w_do_enq) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/echo_multi.sv
// Multi-channel echo: NCH say channels, each buffered in an echo_fifo, drained
// one word per respond_rule firing in round-robin order onto the heard port.
// Optional per-channel forwarded-word counters are built when ECHO_STATS_EN is defined.
module echo_multi
  import echo_pkg::*;
#(
  parameter int NCH   = ECHO_DEF_NCH,
  parameter int WIDTH = ECHO_DEF_WIDTH,
  parameter int DEPTH = ECHO_DEF_DEPTH
) (
  input  logic            CLK,
  input  logic            nRST,
  echo_multi_if.slave     bus
`ifdef ECHO_STATS_EN
  ,
  output logic [NCH*32-1:0] stat_heard_cnt
`endif
);

  localparam int CHW = chan_w(NCH);

  logic [WIDTH-1:0] w_head [NCH];
  logic [NCH-1:0]   w_full;
  logic [NCH-1:0]   w_empty;
  logic [NCH-1:0]   w_pop;
  logic [CHW-1:0]   w_sel;
  logic             w_found;
  logic             w_fire;
  logic [CHW-1:0]   r_rr_last;

  for (genvar g = 0; g < NCH; g++) begin : g_fifo
    echo_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .CLK     (CLK),
      .nRST    (nRST),
      .i_enq   (bus.say__ENA[g]),
      .i_data  (bus.say_v[g*WIDTH +: WIDTH]),
      .i_deq   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
    assign bus.say__RDY[g] = ~w_full[g];
  end

  // Round-robin pick: first non-empty channel after the one drained last.
  // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      int v_idx;
      v_idx = (int'(r_rr_last) + k) % NCH;
      if (!w_found && !w_empty[v_idx]) begin
        w_found = 1'b1;
        w_sel   = CHW'(v_idx);
      end
    end
  end

  assign bus.respond_rule__RDY = w_found & bus.ind_heard__RDY;
  assign w_fire                = bus.respond_rule__ENA & bus.respond_rule__RDY;
  assign w_pop                 = w_fire ? (NCH'(1) << w_sel) : '0;
  assign bus.ind_heard__ENA    = bus.respond_rule__ENA;
  assign bus.ind_heard_v       = w_head[w_sel];
  assign bus.ind_heard_ch      = w_sel;

  // Remember the last drained channel so the next scan starts after it.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_rr_last <= CHW'(NCH - 1);
    end else if (w_fire) begin
      r_rr_last <= w_sel;
    end
  end

`ifdef ECHO_STATS_EN
  logic [31:0] r_stat_cnt [NCH];

  // Count words forwarded per channel; wraps silently at 2^32.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int c = 0; c < NCH; c++) r_stat_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_pop[c]) r_stat_cnt[c] <= r_stat_cnt[c] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_stat
    assign stat_heard_cnt[g*32 +: 32] = r_stat_cnt[g];
  end
`endif

  // Drain must only be fired while it is ready.
  a_drain_when_ready: assert property (@(posedge CLK) disable iff (!nRST)
    bus.respond_rule__ENA |-> bus.respond_rule__RDY);

endmodule

// File: tb/tb_echo_multi.sv
// Self-checking bench for echo_multi: expected heard words are queued when
// says are issued and compared as drains produce them.
module tb_echo_multi;
  import echo_pkg::*;

  localparam int NCH   = 2;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [WIDTH-1:0] v;
    chan_idx_t        ch;
  } exp_t;

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];

  echo_multi_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

`ifdef ECHO_STATS_EN
  logic [NCH*32-1:0] stat_heard_cnt;
`endif

  echo_multi #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef ECHO_STATS_EN
    , .stat_heard_cnt (stat_heard_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.say__ENA          = '0;
    bus.say_v             = '0;
    bus.respond_rule__ENA = 1'b0;
    bus.ind_heard__RDY    = 1'b1;
  endtask

  // Hold reset for two edges; leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    exp_q.delete();
  endtask

  // Accepted say: RDY must be high, word joins the scoreboard.
  task automatic say(input int c, input logic [WIDTH-1:0] d);
    exp_t e;
    bus.say__ENA[c]              = 1'b1;
    bus.say_v[c*WIDTH +: WIDTH]  = d;
    @(negedge CLK);
    check($sformatf("say_rdy_ch%0d", c), 64'(bus.say__RDY[c]), 64'd1);
    e.v  = d;
    e.ch = chan_idx_t'(c);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    bus.say__ENA[c] = 1'b0;
  endtask

  // Say issued while the channel is full: must be refused and not stored.
  task automatic say_blocked(input int c, input logic [WIDTH-1:0] d);
    bus.say__ENA[c]             = 1'b1;
    bus.say_v[c*WIDTH +: WIDTH] = d;
    @(negedge CLK);
    check($sformatf("blocked_rdy_ch%0d", c), 64'(bus.say__RDY[c]), 64'd0);
    @(posedge CLK);
    #1;
    bus.say__ENA[c] = 1'b0;
  endtask

  task automatic compare_heard(input string tag);
    exp_t e;
    check({tag, "_ena"}, 64'(bus.ind_heard__ENA), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_v"},  64'(bus.ind_heard_v),  64'(e.v));
      check({tag, "_ch"}, 64'(bus.ind_heard_ch), 64'(e.ch));
    end
  endtask

  // Wait (bounded) for drain readiness, fire once and compare the heard word.
  task automatic drain(input string tag);
    int waited;
    waited = 0;
    @(negedge CLK);
    while (!bus.respond_rule__RDY && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check({tag, "_rr_rdy"}, 64'(bus.respond_rule__RDY), 64'd1);
    if (bus.respond_rule__RDY) begin
      bus.respond_rule__ENA = 1'b1;
      #1;
      compare_heard(tag);
      @(posedge CLK);
      #1;
      bus.respond_rule__ENA = 1'b0;
    end
  endtask

  // Say and drain in the same cycle; acc tells whether the say must be accepted.
  task automatic say_drain(input int c, input logic [WIDTH-1:0] d, input bit acc, input string tag);
    exp_t e;
    bus.say__ENA[c]             = 1'b1;
    bus.say_v[c*WIDTH +: WIDTH] = d;
    bus.respond_rule__ENA       = 1'b1;
    @(negedge CLK);
    check({tag, "_say_rdy"}, 64'(bus.say__RDY[c]), 64'(acc));
    check({tag, "_rr_rdy"}, 64'(bus.respond_rule__RDY), 64'd1);
    compare_heard(tag);
    if (acc) begin
      e.v  = d;
      e.ch = chan_idx_t'(c);
      exp_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    bus.say__ENA[c]       = 1'b0;
    bus.respond_rule__ENA = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    nRST     = 1'b0;
    idle_inputs();

    // 1 Reset state
    do_reset();
    @(negedge CLK);
    check("rst_say_rdy", 64'(bus.say__RDY), 64'h3);
    check("rst_rr_rdy",  64'(bus.respond_rule__RDY), 64'd0);
    check("rst_ind_ena", 64'(bus.ind_heard__ENA), 64'd0);
    @(posedge CLK);
    #1;

    // 2 Order on one channel; a say into an empty FIFO must not make drain ready that cycle
    bus.say__ENA[0]     = 1'b1;
    bus.say_v[0 +: 32]  = 32'h11;
    @(negedge CLK);
    check("no_bypass_rr_rdy", 64'(bus.respond_rule__RDY), 64'd0);
    @(posedge CLK);
    #1;
    bus.say__ENA[0] = 1'b0;
    exp_q.push_back('{v: 32'h11, ch: chan_idx_t'(0)});
    @(negedge CLK);
    check("after_say_rr_rdy", 64'(bus.respond_rule__RDY), 64'd1);
    @(posedge CLK);
    #1;
    say(0, 32'h22);
    say(0, 32'h33);
    drain("order0");
    drain("order1");
    drain("order2");
    @(negedge CLK);
    check("order_empty_rr_rdy", 64'(bus.respond_rule__RDY), 64'd0);
    @(posedge CLK);
    #1;

    // 3 Round-robin between two loaded channels
    do_reset();
    say(0, 32'hA0);
    say(1, 32'hB0);
    say(0, 32'hA1);
    say(1, 32'hB1);
    for (int i = 0; i < 4; i++) drain($sformatf("rr%0d", i));

    // 4 Full channel, refused say, no pass-through, same-channel enq+deq
    do_reset();
    for (int i = 0; i < DEPTH; i++) say(1, 32'hB000_0000 + 32'(i));
    @(negedge CLK);
    check("full_rdy1", 64'(bus.say__RDY[1]), 64'd0);
    check("full_rdy0", 64'(bus.say__RDY[0]), 64'd1);
    @(posedge CLK);
    #1;
    say_blocked(1, 32'hDEAD_0004);
    say_drain(1, 32'hDEAD_0005, 1'b0, "full_say_drain");
    @(negedge CLK);
    check("rdy_rises_after_pop", 64'(bus.say__RDY[1]), 64'd1);
    @(posedge CLK);
    #1;
    say(1, 32'hB000_0006);
    @(negedge CLK);
    check("refull_rdy1", 64'(bus.say__RDY[1]), 64'd0);
    @(posedge CLK);
    #1;
    drain("full_d0");
    say_drain(1, 32'hB000_0007, 1'b1, "enq_deq_same");
    @(negedge CLK);
    check("count_kept_rdy1", 64'(bus.say__RDY[1]), 64'd1);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) drain($sformatf("full_tail%0d", i));
    @(negedge CLK);
    check("full_empty_rr_rdy", 64'(bus.respond_rule__RDY), 64'd0);
    @(posedge CLK);
    #1;

    // 5 Backpressure and mid-traffic reset
    do_reset();
    bus.ind_heard__RDY = 1'b0;
    say(0, 32'h11);
    say(0, 32'h22);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("bp_rr_rdy", 64'(bus.respond_rule__RDY), 64'd0);
    @(posedge CLK);
    #1;
    bus.ind_heard__RDY = 1'b1;
    drain("bp_first");
    say(1, 32'h33);
    do_reset();
    @(negedge CLK);
    check("midrst_rr_rdy",  64'(bus.respond_rule__RDY), 64'd0);
    check("midrst_say_rdy", 64'(bus.say__RDY), 64'h3);
    @(posedge CLK);
    #1;
    say(0, 32'h44);
    drain("post_rst");

`ifdef ECHO_STATS_EN
    // 6 Per-channel statistics
    do_reset();
    say(0, 32'hC0);
    say(1, 32'hD0);
    say(0, 32'hC1);
    say(0, 32'hC2);
    for (int i = 0; i < 4; i++) drain($sformatf("stat%0d", i));
    @(negedge CLK);
    check("stat_cnt", 64'(stat_heard_cnt), {32'd1, 32'd3});
    @(posedge CLK);
    #1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
